// File: rtl/jtag_idcode_reader.sv
// JTAG initiator reading a single target's 32-bit IDCODE; IDCODE_BYPASS_DETECT_EN adds BYPASS detection.
// Latency 86*CLK_DIV+1 cycles start-to-done (24*CLK_DIV+1 on bypass); start is dropped, not queued, while busy.
module jtag_idcode_reader #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic        TDI_FILL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        tdo_i,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    output logic        busy,
    output logic        done,
    output logic [31:0] idcode,
    output logic        id_valid,
    output logic        lsb_err
`ifdef IDCODE_BYPASS_DETECT_EN
    ,
    output logic        bypass_det
`endif
);

    localparam int unsigned     DW      = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0]   RISE_AT = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]   END_AT  = DW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TLR,
        S_NAV,
        S_SHIFT,
        S_EXIT,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [DW-1:0]  div_q;
    logic [4:0]     cnt_q;
    logic           tck_q;
    logic           tms_q;
    logic           busy_q;
    logic           done_q;
    logic [31:0]    idcode_q;
    logic           id_valid_q;
    logic           lsb_err_q;
`ifdef IDCODE_BYPASS_DETECT_EN
    logic           byp_q;
    logic           bypass_det_q;
`endif

    state_t         state_d;
    logic [4:0]     cnt_d;
    logic           tms_d;
    logic           byp_hit;

`ifdef IDCODE_BYPASS_DETECT_EN
    assign byp_hit = byp_q;
`else
    assign byp_hit = 1'b0;
`endif

    // Next slot selection; tms_d is the TMS level the upcoming slot presents.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        tms_d   = 1'b1;
        case (state_q)
            S_TLR: begin
                if (cnt_q == 5'd4) begin
                    state_d = S_NAV;
                    cnt_d   = 5'd0;
                    tms_d   = 1'b0;
                end
            end
            S_NAV: begin
                if (cnt_q == 5'd3) begin
                    state_d = S_SHIFT;
                    cnt_d   = 5'd0;
                    tms_d   = 1'b0;
                end else begin
                    tms_d = (cnt_q == 5'd0);
                end
            end
            S_SHIFT: begin
                if (cnt_q == 5'd31) begin
                    state_d = S_EXIT;
                    cnt_d   = 5'd0;
                    tms_d   = 1'b1;
                end else if (byp_hit && cnt_q == 5'd0) begin
                    // Jump straight to the Exit1-DR slot; no further bits are captured.
                    cnt_d = 5'd31;
                    tms_d = 1'b1;
                end else begin
                    tms_d = (cnt_q == 5'd30);
                end
            end
            S_EXIT: begin
                if (cnt_q == 5'd1 || byp_hit) begin
                    state_d = S_DONE;
                    cnt_d   = 5'd0;
                    tms_d   = 1'b1;
                end else begin
                    tms_d = 1'b0;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idcode_q   <= '0;
            id_valid_q <= 1'b0;
            lsb_err_q  <= 1'b0;
`ifdef IDCODE_BYPASS_DETECT_EN
            byp_q        <= 1'b0;
            bypass_det_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tck_q  <= 1'b0;
                    tms_q  <= 1'b1;
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= S_TLR;
                        busy_q     <= 1'b1;
                        div_q      <= '0;
                        cnt_q      <= '0;
                        idcode_q   <= '0;
                        id_valid_q <= 1'b0;
                        lsb_err_q  <= 1'b0;
`ifdef IDCODE_BYPASS_DETECT_EN
                        byp_q        <= 1'b0;
                        bypass_det_q <= 1'b0;
`endif
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    if (div_q == END_AT) begin
                        div_q   <= '0;
                        tck_q   <= 1'b0;
                        state_q <= state_d;
                        cnt_q   <= cnt_d;
                        tms_q   <= tms_d;
                        if (state_d == S_DONE) begin
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            id_valid_q <= idcode_q[0] & ~byp_hit;
                            lsb_err_q  <= ~idcode_q[0] & ~byp_hit;
`ifdef IDCODE_BYPASS_DETECT_EN
                            bypass_det_q <= byp_q;
`endif
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                        if (div_q == RISE_AT) begin
                            tck_q <= 1'b1;
                            // tdo_i is sampled on the same clk edge that raises TCK.
                            if (state_q == S_SHIFT && !byp_hit) begin
                                idcode_q[cnt_q] <= tdo_i;
                            end
`ifdef IDCODE_BYPASS_DETECT_EN
                            if (state_q == S_SHIFT && cnt_q == 5'd0 && !tdo_i) begin
                                byp_q <= 1'b1;
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign tck_o    = tck_q;
    assign tms_o    = tms_q;
    assign tdi_o    = TDI_FILL;
    assign busy     = busy_q;
    assign done     = done_q;
    assign idcode   = idcode_q;
    assign id_valid = id_valid_q;
    assign lsb_err  = lsb_err_q;
`ifdef IDCODE_BYPASS_DETECT_EN
    assign bypass_det = bypass_det_q;
`endif

endmodule
